// File: rtl/id_stage.sv
// id_stage: decode stage between fetch and execute.
// Decodes the fetched instruction, drives the register file read addresses, builds the
// sign-extended immediate and holds everything in the ID/EX pipeline register.
// It also detects load-use hazards and inserts a single bubble when one occurs.
// Optional feature macro: ID_WB_BYPASS_EN forwards a same-cycle write-back into the operands,
// both when an instruction is captured and while a stalled ID/EX entry is held.
module id_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid_i,
    output logic               if_ready_o,
    input  logic [31:0]        if_instr_i,
    input  logic [XLEN-1:0]    if_pc_i,
    output logic [RADDR_W-1:0] rf_a1_o,
    output logic [RADDR_W-1:0] rf_a2_o,
    input  logic [XLEN-1:0]    rf_rd1_i,
    input  logic [XLEN-1:0]    rf_rd2_i,
    input  logic               wb_we_i,
    input  logic [4:0]         wb_rd_i,
    input  logic [XLEN-1:0]    wb_data_i,
    input  logic               ex_ready_i,
    input  logic               ex_flush_i,
    output logic               ex_valid_o,
    output logic [XLEN-1:0]    ex_pc_o,
    output logic [6:0]         ex_opcode_o,
    output logic [2:0]         ex_funct3_o,
    output logic [6:0]         ex_funct7_o,
    output logic [4:0]         ex_rs1_o,
    output logic [4:0]         ex_rs2_o,
    output logic [4:0]         ex_rd_o,
    output logic [XLEN-1:0]    ex_rs1_val_o,
    output logic [XLEN-1:0]    ex_rs2_val_o,
    output logic [XLEN-1:0]    ex_imm_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // ID/EX pipeline register state
    logic            ex_valid_q,   ex_valid_d;
    logic [XLEN-1:0] ex_pc_q,      ex_pc_d;
    logic [6:0]      ex_opcode_q,  ex_opcode_d;
    logic [2:0]      ex_funct3_q,  ex_funct3_d;
    logic [6:0]      ex_funct7_q,  ex_funct7_d;
    logic [4:0]      ex_rs1_q,     ex_rs1_d;
    logic [4:0]      ex_rs2_q,     ex_rs2_d;
    logic [4:0]      ex_rd_q,      ex_rd_d;
    logic [XLEN-1:0] ex_rs1_val_q, ex_rs1_val_d;
    logic [XLEN-1:0] ex_rs2_val_q, ex_rs2_val_d;
    logic [XLEN-1:0] ex_imm_q,     ex_imm_d;

    // Decoded fields of the incoming instruction
    logic [6:0]      dec_opcode;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [4:0]      dec_rd;
    logic            dec_uses_rs2;
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_rs1_val;
    logic [XLEN-1:0] dec_rs2_val;
    logic            hazard;
    logic            ready;
    logic            load;

    assign dec_opcode   = if_instr_i[6:0];
    assign dec_rd       = if_instr_i[11:7];
    assign dec_rs1      = if_instr_i[19:15];
    assign dec_rs2      = if_instr_i[24:20];
    assign dec_uses_rs2 = (dec_opcode == OP_REG) || (dec_opcode == OP_STORE) ||
                          (dec_opcode == OP_BRANCH);

    assign rf_a1_o = {{(RADDR_W-5){1'b0}}, dec_rs1};
    assign rf_a2_o = {{(RADDR_W-5){1'b0}}, dec_rs2};

`ifdef ID_WB_BYPASS_EN
    // Operand source: x0 is always zero, otherwise a same-cycle write-back wins over the regfile.
    function automatic logic [XLEN-1:0] pick_operand(input logic [4:0]      idx,
                                                     input logic [XLEN-1:0] rf_val,
                                                     input logic            we,
                                                     input logic [4:0]      wrd,
                                                     input logic [XLEN-1:0] wdata);
        if (idx == 5'd0) begin
            return '0;
        end else if (we && (wrd == idx)) begin
            return wdata;
        end
        return rf_val;
    endfunction
`else
    // Operand source: x0 is always zero, otherwise the regfile value as read this cycle.
    function automatic logic [XLEN-1:0] pick_operand(input logic [4:0]      idx,
                                                     input logic [XLEN-1:0] rf_val);
        if (idx == 5'd0) begin
            return '0;
        end
        return rf_val;
    endfunction

    // Write-back port only matters when bypassing is built in.
    logic unused_wb;
    assign unused_wb = ^{wb_we_i, wb_rd_i, wb_data_i};
`endif

    // Select the operand values for the instruction being decoded.
    always_comb begin
`ifdef ID_WB_BYPASS_EN
        dec_rs1_val = pick_operand(dec_rs1, rf_rd1_i, wb_we_i, wb_rd_i, wb_data_i);
        dec_rs2_val = pick_operand(dec_rs2, rf_rd2_i, wb_we_i, wb_rd_i, wb_data_i);
`else
        dec_rs1_val = pick_operand(dec_rs1, rf_rd1_i);
        dec_rs2_val = pick_operand(dec_rs2, rf_rd2_i);
`endif
    end

    // Build the 32-bit immediate by instruction format; every format sign-extends from bit 31.
    always_comb begin
        dec_imm32 = 32'd0;
        case (dec_opcode)
            OP_LOAD, OP_IMM, OP_JALR:
                dec_imm32 = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
            OP_STORE:
                dec_imm32 = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
            OP_BRANCH:
                dec_imm32 = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                             if_instr_i[30:25], if_instr_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                dec_imm32 = {if_instr_i[31:12], 12'd0};
            OP_JAL:
                dec_imm32 = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                             if_instr_i[20], if_instr_i[30:21], 1'b0};
            default:
                dec_imm32 = 32'd0;
        endcase
    end

    // Load-use hazard: a load in ID/EX whose destination feeds the incoming instruction.
    always_comb begin
        hazard = ex_valid_q && (ex_opcode_q == OP_LOAD) && (ex_rd_q != 5'd0) && if_valid_i &&
                 ((ex_rd_q == dec_rs1) || ((ex_rd_q == dec_rs2) && dec_uses_rs2));
        ready  = (!ex_valid_q || ex_ready_i) && !hazard && !ex_flush_i;
        load   = if_valid_i && ready;
    end

    assign if_ready_o = ready;

    // Next ID/EX contents: capture on load, otherwise hold (bubbling valid when execute drains it).
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_opcode_d  = ex_opcode_q;
        ex_funct3_d  = ex_funct3_q;
        ex_funct7_d  = ex_funct7_q;
        ex_rs1_d     = ex_rs1_q;
        ex_rs2_d     = ex_rs2_q;
        ex_rd_d      = ex_rd_q;
        ex_rs1_val_d = ex_rs1_val_q;
        ex_rs2_val_d = ex_rs2_val_q;
        ex_imm_d     = ex_imm_q;

        if (load) begin
            ex_valid_d   = 1'b1;
            ex_pc_d      = if_pc_i;
            ex_opcode_d  = dec_opcode;
            ex_funct3_d  = if_instr_i[14:12];
            ex_funct7_d  = if_instr_i[31:25];
            ex_rs1_d     = dec_rs1;
            ex_rs2_d     = dec_rs2;
            ex_rd_d      = dec_rd;
            ex_rs1_val_d = dec_rs1_val;
            ex_rs2_val_d = dec_rs2_val;
            ex_imm_d     = XLEN'($signed(dec_imm32));
        end else begin
            if (ex_flush_i || ex_ready_i) begin
                ex_valid_d = 1'b0;
            end
`ifdef ID_WB_BYPASS_EN
            // A held instruction picks up write-backs to its sources so it never issues stale data.
            if (wb_we_i && (wb_rd_i == ex_rs1_q) && (ex_rs1_q != 5'd0)) begin
                ex_rs1_val_d = wb_data_i;
            end
            if (wb_we_i && (wb_rd_i == ex_rs2_q) && (ex_rs2_q != 5'd0)) begin
                ex_rs2_val_d = wb_data_i;
            end
`endif
        end
    end

    // ID/EX register; reset clears everything so no in-flight instruction survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_opcode_q  <= '0;
            ex_funct3_q  <= '0;
            ex_funct7_q  <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_rd_q      <= '0;
            ex_rs1_val_q <= '0;
            ex_rs2_val_q <= '0;
            ex_imm_q     <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_opcode_q  <= ex_opcode_d;
            ex_funct3_q  <= ex_funct3_d;
            ex_funct7_q  <= ex_funct7_d;
            ex_rs1_q     <= ex_rs1_d;
            ex_rs2_q     <= ex_rs2_d;
            ex_rd_q      <= ex_rd_d;
            ex_rs1_val_q <= ex_rs1_val_d;
            ex_rs2_val_q <= ex_rs2_val_d;
            ex_imm_q     <= ex_imm_d;
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_pc_o      = ex_pc_q;
    assign ex_opcode_o  = ex_opcode_q;
    assign ex_funct3_o  = ex_funct3_q;
    assign ex_funct7_o  = ex_funct7_q;
    assign ex_rs1_o     = ex_rs1_q;
    assign ex_rs2_o     = ex_rs2_q;
    assign ex_rd_o      = ex_rd_q;
    assign ex_rs1_val_o = ex_rs1_val_q;
    assign ex_rs2_val_o = ex_rs2_val_q;
    assign ex_imm_o     = ex_imm_q;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed testbench for id_stage.
// Inputs change on the falling edge; combinational outputs are checked shortly after,
// registered outputs on the following falling edge.
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [31:0] if_instr_i;
    logic [31:0] if_pc_i;
    logic [5:0]  rf_a1_o;
    logic [5:0]  rf_a2_o;
    logic [31:0] rf_rd1_i;
    logic [31:0] rf_rd2_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        ex_ready_i;
    logic        ex_flush_i;
    logic        ex_valid_o;
    logic [31:0] ex_pc_o;
    logic [6:0]  ex_opcode_o;
    logic [2:0]  ex_funct3_o;
    logic [6:0]  ex_funct7_o;
    logic [4:0]  ex_rs1_o;
    logic [4:0]  ex_rs2_o;
    logic [4:0]  ex_rd_o;
    logic [31:0] ex_rs1_val_o;
    logic [31:0] ex_rs2_val_o;
    logic [31:0] ex_imm_o;

    int testCount = 0;
    int failCount = 0;

    id_stage #(.XLEN(32), .RADDR_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_valid_i   (if_valid_i),
        .if_ready_o   (if_ready_o),
        .if_instr_i   (if_instr_i),
        .if_pc_i      (if_pc_i),
        .rf_a1_o      (rf_a1_o),
        .rf_a2_o      (rf_a2_o),
        .rf_rd1_i     (rf_rd1_i),
        .rf_rd2_i     (rf_rd2_i),
        .wb_we_i      (wb_we_i),
        .wb_rd_i      (wb_rd_i),
        .wb_data_i    (wb_data_i),
        .ex_ready_i   (ex_ready_i),
        .ex_flush_i   (ex_flush_i),
        .ex_valid_o   (ex_valid_o),
        .ex_pc_o      (ex_pc_o),
        .ex_opcode_o  (ex_opcode_o),
        .ex_funct3_o  (ex_funct3_o),
        .ex_funct7_o  (ex_funct7_o),
        .ex_rs1_o     (ex_rs1_o),
        .ex_rs2_o     (ex_rs2_o),
        .ex_rd_o      (ex_rd_o),
        .ex_rs1_val_o (ex_rs1_val_o),
        .ex_rs2_val_o (ex_rs2_val_o),
        .ex_imm_o     (ex_imm_o)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the fetch/execute handshake inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic exReady,
                                 input logic flush);
        if_valid_i = valid;
        if_instr_i = instr;
        if_pc_i    = pc;
        ex_ready_i = exReady;
        ex_flush_i = flush;
        #1;
    endtask

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one clock and land on the next falling edge.
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Directed test sequence.
    initial begin
        logic [31:0] bypassExp;
        rst_n      = 1'b0;
        if_valid_i = 1'b0;
        if_instr_i = 32'd0;
        if_pc_i    = 32'd0;
        rf_rd1_i   = 32'd0;
        rf_rd2_i   = 32'd0;
        wb_we_i    = 1'b0;
        wb_rd_i    = 5'd0;
        wb_data_i  = 32'd0;
        ex_ready_i = 1'b1;
        ex_flush_i = 1'b0;

        // Reset state
        #2;
        checkOutput("reset_valid", {31'd0, ex_valid_o}, 32'd0);
        checkOutput("reset_pc", ex_pc_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_reset", {31'd0, if_ready_o}, 32'd1);

        // addi x5,x0,-1
        applyStimulus(1'b1, 32'hFFF00293, 32'h0000_0100, 1'b1, 1'b0);
        checkOutput("addi_ready", {31'd0, if_ready_o}, 32'd1);
        checkOutput("addi_a1", {26'd0, rf_a1_o}, 32'd0);
        checkOutput("addi_a2", {26'd0, rf_a2_o}, 32'd31);
        stepCycle();
        checkOutput("addi_valid", {31'd0, ex_valid_o}, 32'd1);
        checkOutput("addi_imm", ex_imm_o, 32'hFFFF_FFFF);
        checkOutput("addi_rd", {27'd0, ex_rd_o}, 32'd5);
        checkOutput("addi_rs1_val", ex_rs1_val_o, 32'd0);
        checkOutput("addi_pc", ex_pc_o, 32'h0000_0100);
        checkOutput("addi_opcode", {25'd0, ex_opcode_o}, 32'h13);

        // lw x6,0(x1) followed by dependent add x7,x6,x2
        rf_rd1_i = 32'h0000_0011;
        applyStimulus(1'b1, 32'h0000A303, 32'h0000_0104, 1'b1, 1'b0);
        checkOutput("lw_ready", {31'd0, if_ready_o}, 32'd1);
        stepCycle();
        checkOutput("lw_valid", {31'd0, ex_valid_o}, 32'd1);
        checkOutput("lw_opcode", {25'd0, ex_opcode_o}, 32'h03);
        checkOutput("lw_funct3", {29'd0, ex_funct3_o}, 32'd2);
        checkOutput("lw_rs1_val", ex_rs1_val_o, 32'h0000_0011);
        applyStimulus(1'b1, 32'h002303B3, 32'h0000_0108, 1'b1, 1'b0);
        checkOutput("hazard_ready", {31'd0, if_ready_o}, 32'd0);
        checkOutput("add_a1", {26'd0, rf_a1_o}, 32'd6);
        checkOutput("add_a2", {26'd0, rf_a2_o}, 32'd2);
        stepCycle();
        checkOutput("bubble_valid", {31'd0, ex_valid_o}, 32'd0);
        checkOutput("after_bubble_ready", {31'd0, if_ready_o}, 32'd1);
        rf_rd1_i = 32'h0000_0066;
        rf_rd2_i = 32'h0000_0022;
        stepCycle();
        checkOutput("add_valid", {31'd0, ex_valid_o}, 32'd1);
        checkOutput("add_pc", ex_pc_o, 32'h0000_0108);
        checkOutput("add_rs1_val", ex_rs1_val_o, 32'h0000_0066);
        checkOutput("add_rs2_val", ex_rs2_val_o, 32'h0000_0022);
        checkOutput("add_rd", {27'd0, ex_rd_o}, 32'd7);

        // Load followed by addi whose unused rs2 field matches the load destination: no hazard
        applyStimulus(1'b1, 32'h0000A303, 32'h0000_0180, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 32'h00600493, 32'h0000_0184, 1'b1, 1'b0);
        checkOutput("rs2_unused_ready", {31'd0, if_ready_o}, 32'd1);
        stepCycle();
        checkOutput("rs2_unused_pc", ex_pc_o, 32'h0000_0184);
        // Load followed by a store using the load result as rs2: hazard
        applyStimulus(1'b1, 32'h0000A103, 32'h0000_0188, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 32'hFE20AE23, 32'h0000_018C, 1'b1, 1'b0);
        checkOutput("store_hazard_ready", {31'd0, if_ready_o}, 32'd0);
        stepCycle();
        stepCycle();
        checkOutput("sw_imm", ex_imm_o, 32'hFFFF_FFFC);
        checkOutput("sw_funct7", {25'd0, ex_funct7_o}, 32'h7F);
        checkOutput("sw_rs2", {27'd0, ex_rs2_o}, 32'd2);

        // add x3,x4,x4 with a same-cycle write-back to x4
`ifdef ID_WB_BYPASS_EN
        bypassExp = 32'h0000_1234;
`else
        bypassExp = 32'h0000_0000;
`endif
        rf_rd1_i  = 32'd0;
        rf_rd2_i  = 32'd0;
        wb_we_i   = 1'b1;
        wb_rd_i   = 5'd4;
        wb_data_i = 32'h0000_1234;
        applyStimulus(1'b1, 32'h004201B3, 32'h0000_010C, 1'b1, 1'b0);
        stepCycle();
        checkOutput("bypass_rs1_val", ex_rs1_val_o, bypassExp);
        checkOutput("bypass_rs2_val", ex_rs2_val_o, bypassExp);
        // add x3,x0,x0 with write-back targeting x0: never bypassed
        wb_rd_i   = 5'd0;
        wb_data_i = 32'h0000_5678;
        applyStimulus(1'b1, 32'h000001B3, 32'h0000_0110, 1'b1, 1'b0);
        stepCycle();
        checkOutput("x0_rs1_val", ex_rs1_val_o, 32'd0);
        checkOutput("x0_rs2_val", ex_rs2_val_o, 32'd0);

        // Execute stalls for three cycles while fetch offers addi x8,x0,5
        wb_data_i = 32'h0000_9999;
        applyStimulus(1'b1, 32'h00500413, 32'h0000_0300, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_ready", {31'd0, if_ready_o}, 32'd0);
            stepCycle();
            checkOutput("stall_valid", {31'd0, ex_valid_o}, 32'd1);
            checkOutput("stall_pc", ex_pc_o, 32'h0000_0110);
            checkOutput("stall_rd", {27'd0, ex_rd_o}, 32'd3);
            checkOutput("stall_rs1_val", ex_rs1_val_o, 32'd0);
        end
        wb_we_i = 1'b0;
        applyStimulus(1'b1, 32'h00500413, 32'h0000_0300, 1'b0, 1'b1);
        checkOutput("flush_ready", {31'd0, if_ready_o}, 32'd0);
        stepCycle();
        checkOutput("flush_valid", {31'd0, ex_valid_o}, 32'd0);
        applyStimulus(1'b1, 32'h00500413, 32'h0000_0300, 1'b1, 1'b0);
        checkOutput("post_flush_ready", {31'd0, if_ready_o}, 32'd1);
        stepCycle();
        checkOutput("pending_valid", {31'd0, ex_valid_o}, 32'd1);
        checkOutput("pending_pc", ex_pc_o, 32'h0000_0300);
        checkOutput("pending_imm", ex_imm_o, 32'd5);
        checkOutput("pending_rd", {27'd0, ex_rd_o}, 32'd8);

        // Immediate formats: jal, beq, lui
        applyStimulus(1'b1, 32'h001000EF, 32'h0000_0400, 1'b1, 1'b0);
        stepCycle();
        checkOutput("jal_imm", ex_imm_o, 32'h0000_0800);
        checkOutput("jal_rd", {27'd0, ex_rd_o}, 32'd1);
        applyStimulus(1'b1, 32'hFE000CE3, 32'h0000_0404, 1'b1, 1'b0);
        stepCycle();
        checkOutput("beq_imm", ex_imm_o, 32'hFFFF_FFF8);
        applyStimulus(1'b1, 32'h123452B7, 32'h0000_0408, 1'b1, 1'b0);
        stepCycle();
        checkOutput("lui_imm", ex_imm_o, 32'h1234_5000);
        checkOutput("lui_valid", {31'd0, ex_valid_o}, 32'd1);

        // Reset asserted mid-stream clears ID/EX immediately
        applyStimulus(1'b1, 32'hFFF00293, 32'h0000_0500, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", {31'd0, ex_valid_o}, 32'd0);
        checkOutput("midreset_pc", ex_pc_o, 32'd0);
        checkOutput("midreset_imm", ex_imm_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("midreset_ready", {31'd0, if_ready_o}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
